// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with a valid/ready handshake and an optional 2-entry skid buffer.
// SKID_EN = 1 keeps in_ready registered. in_ready then depends only on the held state, flush and rst.
// SKID_EN = 0 is a single register whose in_ready follows the downstream handshake combinationally.
// flush kills all held entries synchronously. stall blocks the output transfer.
// Build option: define PIPE_STAGE_PERF_EN to add the saturating stall_cnt/flush_cnt outputs.
module pipe_stage_skid #(
   parameter int unsigned       DATA_W  = 96,
   parameter logic [DATA_W-1:0] BUBBLE  = DATA_W'({32'h0000_0013, 64'h0}),
   parameter bit                SKID_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              stall,
   input  logic              flush
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_fire;
   logic              out_fire;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   // Payload registers; both hold BUBBLE whenever they carry no valid entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q <= BUBBLE;
         skid_q <= BUBBLE;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end

   // Next-state and payload selection; flush overrides every other event
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = StEmpty;
         main_d  = BUBBLE;
         skid_d  = BUBBLE;
      end else begin
         case (state_q)
            StEmpty: begin
               if (in_fire) begin
                  main_d  = in_data;
                  state_d = StBusy;
               end
            end
            StBusy: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  // Only reachable with the skid buffer present
                  if (SKID_EN) begin
                     skid_d  = in_data;
                     state_d = StFull;
                  end
               end else if (out_fire) begin
                  main_d  = BUBBLE;
                  state_d = StEmpty;
               end
            end
            StFull: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  skid_d  = BUBBLE;
                  state_d = StBusy;
               end
            end
            default: begin
               state_d = StEmpty;
               main_d  = BUBBLE;
               skid_d  = BUBBLE;
            end
         endcase
      end
   end

   // Handshake outputs
   always_comb begin
      out_valid = (state_q != StEmpty);
      out_data  = main_q;
      out_fire  = out_valid & out_ready & ~stall;
      if (SKID_EN) begin
         // Registered ready: no path from out_ready or stall
         in_ready = (state_q != StFull) & ~flush & ~rst;
      end else begin
         in_ready = (~out_valid | out_fire) & ~flush & ~rst;
      end
      in_fire = in_valid & in_ready;
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   // Saturating counters of blocked-output cycles and of flushes that killed live entries
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (out_valid && !out_fire && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (flush && (state_q != StEmpty) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid.
// Drives one skid instance (a_*) and one single-register instance (b_*) with identical inputs.
// Each instance has its own queue model. Outputs are compared at the falling edge.
// Optional: PIPE_STAGE_PERF_EN also checks the performance counters.
module tb_pipe_stage_skid;

   localparam int unsigned   DW     = 96;
   localparam logic [DW-1:0] BUBBLE = {32'h0000_0013, 64'h0};

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          out_ready;
   logic          stall;
   logic          flush;

   logic          a_in_ready, a_out_valid;
   logic [DW-1:0] a_out_data;
   logic          b_in_ready, b_out_valid;
   logic [DW-1:0] b_out_data;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0]   a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
   logic [31:0]   a_sc, a_fc, b_sc, b_fc;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   logic [DW-1:0] qa[$];
   logic [DW-1:0] qb[$];

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(DW), .BUBBLE(BUBBLE), .SKID_EN(1'b1)) u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (a_in_ready),
      .in_data   (in_data),
      .out_valid (a_out_valid),
      .out_ready (out_ready),
      .out_data  (a_out_data),
      .stall     (stall),
      .flush     (flush)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt (a_stall_cnt),
      .flush_cnt (a_flush_cnt)
`endif
   );

   pipe_stage_skid #(.DATA_W(DW), .BUBBLE(BUBBLE), .SKID_EN(1'b0)) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (b_in_ready),
      .in_data   (in_data),
      .out_valid (b_out_valid),
      .out_ready (out_ready),
      .out_data  (b_out_data),
      .stall     (stall),
      .flush     (flush)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt (b_stall_cnt),
      .flush_cnt (b_flush_cnt)
`endif
   );

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, compare at negedge, advance both models at posedge
   task automatic cycle(input logic iv, input logic [DW-1:0] id, input logic ordy,
                        input logic stl, input logic fl);
      logic a_ov, a_of, a_ir, b_ov, b_of, b_ir;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      stall     = stl;
      flush     = fl;
      @(negedge clk);
      a_ov = (qa.size() != 0);
      a_of = a_ov & ordy & ~stl;
      a_ir = (qa.size() < 2) & ~fl & ~rst;
      b_ov = (qb.size() != 0);
      b_of = b_ov & ordy & ~stl;
      b_ir = (~b_ov | b_of) & ~fl & ~rst;
      check("a_out_valid", DW'(a_out_valid), DW'(a_ov));
      check("a_out_data", a_out_data, a_ov ? qa[0] : BUBBLE);
      check("a_in_ready", DW'(a_in_ready), DW'(a_ir));
      check("b_out_valid", DW'(b_out_valid), DW'(b_ov));
      check("b_out_data", b_out_data, b_ov ? qb[0] : BUBBLE);
      check("b_in_ready", DW'(b_in_ready), DW'(b_ir));
`ifdef PIPE_STAGE_PERF_EN
      check("a_stall_cnt", DW'(a_stall_cnt), DW'(a_sc));
      check("a_flush_cnt", DW'(a_flush_cnt), DW'(a_fc));
      check("b_stall_cnt", DW'(b_stall_cnt), DW'(b_sc));
      check("b_flush_cnt", DW'(b_flush_cnt), DW'(b_fc));
`endif
      @(posedge clk);
      if (!rst) begin
`ifdef PIPE_STAGE_PERF_EN
         if (a_ov && !a_of && !fl) a_sc++;
         if (b_ov && !b_of && !fl) b_sc++;
         if (fl && qa.size() != 0) a_fc++;
         if (fl && qb.size() != 0) b_fc++;
`endif
         if (fl) begin
            qa.delete();
            qb.delete();
         end else begin
            if (a_of) void'(qa.pop_front());
            if (iv && a_ir) qa.push_back(id);
            if (b_of) void'(qb.pop_front());
            if (iv && b_ir) qb.push_back(id);
         end
      end
      #1;
   endtask

   // Asynchronous reset between clock edges while traffic is held
   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      check("rst_a_out_valid", DW'(a_out_valid), DW'(1'b0));
      check("rst_a_out_data", a_out_data, BUBBLE);
      check("rst_a_in_ready", DW'(a_in_ready), DW'(1'b0));
      check("rst_b_out_valid", DW'(b_out_valid), DW'(1'b0));
      check("rst_b_out_data", b_out_data, BUBBLE);
      qa.delete();
      qb.delete();
`ifdef PIPE_STAGE_PERF_EN
      a_sc = 0; a_fc = 0; b_sc = 0; b_fc = 0;
`endif
      @(posedge clk);
      #1;
      cycle(1'b1, DW'(32'hEE), 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      stall     = 1'b0;
      flush     = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
      a_sc = 0; a_fc = 0; b_sc = 0; b_fc = 0;
`endif
      repeat (2) @(posedge clk);
      #1;
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      // Single transfer after reset
      cycle(1'b1, DW'(32'hA), 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Skid fill: 0x3 is held off until the buffer drains
      cycle(1'b1, DW'(32'h1), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, DW'(32'h2), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, DW'(32'h3), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, DW'(32'h3), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, DW'(32'h3), 1'b1, 1'b0, 1'b0);
      cycle(1'b1, DW'(32'h3), 1'b1, 1'b0, 1'b0);
      repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Stall in FULL for 5 cycles with out_ready high
      cycle(1'b1, DW'(32'h4), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, DW'(32'h5), 1'b0, 1'b0, 1'b0);
      repeat (5) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);

      // Flush in FULL together with an input
      cycle(1'b1, DW'(32'h6), 1'b1, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Streaming: output trails input by one cycle
      for (int i = 0; i < 100; i++) begin
         cycle(1'b1, DW'(32'h100 + i), 1'b1, 1'b0, 1'b0);
      end
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Single-register ready drops combinationally; stall with flush loses to flush
      cycle(1'b1, DW'(32'h7), 1'b1, 1'b0, 1'b0);
      cycle(1'b1, DW'(32'h8), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, DW'(32'h9), 1'b1, 1'b1, 1'b1);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom},
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 15) == 0));
      end

      // Asynchronous reset mid-traffic, then a single transfer
      cycle(1'b1, DW'(32'hB), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, DW'(32'hC), 1'b0, 1'b0, 1'b0);
      async_reset();
      cycle(1'b1, DW'(32'hA), 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
